// File: rtl/rvfi_progress_check.sv
// Forward-progress checker for the RVFI bus: first-retirement timeout, stall window,
// retirement counting and a trig-to-check minimum. Optional macro: RVFI_PROGRESS_EXEMPT_EN.
module rvfi_progress_check #(
    parameter int NRET         = 1,
    parameter int ILEN         = 32,
    parameter int CNT_W        = 8,
    parameter int INIT_TIMEOUT = 64,
    parameter int MAX_STALL    = 16,
    parameter int MIN_RETIRE   = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 trig,
    input  logic                 check,
    input  logic                 waive,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET-1:0]      rvfi_halt,
    input  logic [NRET*ILEN-1:0] rvfi_insn,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic                 fail,
    output logic [1:0]           fail_code
);

    typedef enum logic [1:0] {
        ST_WAIT_FIRST = 2'd0,
        ST_RUN        = 2'd1,
        ST_EXEMPT     = 2'd2,
        ST_FAIL       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_INIT  = 2'd1,
        FC_STALL = 2'd2,
        FC_CHECK = 2'd3
    } fail_code_e;

    localparam int RN_W  = $clog2(NRET + 1);
    localparam int SUM_W = CNT_W + RN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    fail_code_e       r_fail_code;
    logic             r_fail;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    logic [NRET-1:0]  w_exempt;
    logic [RN_W-1:0]  w_ret_n;
    logic             w_exempt_hit;
    logic             w_retire;
    logic [SUM_W-1:0] w_win;
    logic [CNT_W-1:0] w_retire_nxt;
    logic [CNT_W-1:0] w_stall_nxt;
    logic             w_check_fail;
    logic             w_init_to;
    logic             w_stall_to;

`ifdef RVFI_PROGRESS_EXEMPT_EN
    localparam logic [ILEN-1:0] WFI_INSN = ILEN'(32'h1050_0073);

    always_comb begin
        w_exempt = '0;
        for (int c = 0; c < NRET; c++) begin
            w_exempt[c] = rvfi_halt[c] || (rvfi_insn[c*ILEN +: ILEN] == WFI_INSN);
        end
    end
`else
    // Without exemption halt and WFI are ordinary retirements.
    logic w_unused_exempt;
    assign w_exempt        = '0;
    assign w_unused_exempt = ^{rvfi_halt, rvfi_insn};
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_ret_n      = '0;
        w_exempt_hit = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c]) begin
                if (w_exempt[c]) w_exempt_hit = 1'b1;
                else             w_ret_n      = w_ret_n + RN_W'(1);
            end
        end
    end

    assign w_retire = (w_ret_n != '0);

    // Window count including this cycle; trig restarts the window at this cycle.
    assign w_win        = trig ? SUM_W'(w_ret_n) : SUM_W'(r_retire_cnt) + SUM_W'(w_ret_n);
    assign w_retire_nxt = (w_win > SUM_W'(CNT_MAX)) ? CNT_MAX : w_win[CNT_W-1:0];
    assign w_check_fail = check && (w_win < SUM_W'(MIN_RETIRE));

    always_comb begin
        w_stall_nxt = r_stall_cnt;
        if (w_retire || trig)           w_stall_nxt = '0;
        else if (!waive && r_stall_cnt != CNT_MAX) w_stall_nxt = r_stall_cnt + CNT_W'(1);
    end

    assign w_init_to  = (r_stall_cnt == CNT_W'(INIT_TIMEOUT - 1)) && !w_retire && !waive;
    assign w_stall_to = (r_stall_cnt == CNT_W'(MAX_STALL - 1))    && !w_retire && !waive;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_WAIT_FIRST;
            r_fail       <= 1'b0;
            r_fail_code  <= FC_NONE;
            r_stall_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (r_state != ST_FAIL) begin
            r_retire_cnt <= w_retire_nxt;
            r_stall_cnt  <= w_stall_nxt;
            case (r_state)
                ST_WAIT_FIRST: begin
                    if (w_retire) begin
                        if (w_check_fail) begin
                            r_state     <= ST_FAIL;
                            r_fail      <= 1'b1;
                            r_fail_code <= FC_CHECK;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (w_exempt_hit) begin
                        r_state     <= ST_EXEMPT;
                        r_stall_cnt <= '0;
                    end else if (w_init_to) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_INIT;
                    end else if (w_check_fail) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_CHECK;
                    end
                end
                ST_RUN: begin
                    // Exemption outranks both the stall timeout and the check.
                    if (w_exempt_hit) begin
                        r_state     <= ST_EXEMPT;
                        r_stall_cnt <= '0;
                    end else if (w_stall_to) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_STALL;
                    end else if (w_check_fail) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_fail_code <= FC_CHECK;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign stall_cnt  = r_stall_cnt;
    assign retire_cnt = r_retire_cnt;
    assign fail       = r_fail;
    assign fail_code  = r_fail_code;

endmodule

// File: tb/tb_rvfi_progress_check.sv
// Scoreboard bench for rvfi_progress_check: stimulus queues expected snapshots per edge,
// a monitor compares them on the falling edge (or immediately for async reset checks).
module tb_rvfi_progress_check;

    localparam int NRET  = 2;
    localparam int ILEN  = 32;
    localparam int CNT_W = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WFI = 32'h1050_0073;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              trig = 1'b0;
    logic              check = 1'b0;
    logic              waive = 1'b0;
    logic [NRET-1:0]   rvfi_valid = '0;
    logic [NRET-1:0]   rvfi_halt = '0;
    logic [NRET*ILEN-1:0] rvfi_insn = '0;
    logic [1:0]        state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  retire_cnt;
    logic              fail;
    logic [1:0]        fail_code;

    rvfi_progress_check #(
        .NRET(NRET), .ILEN(ILEN), .CNT_W(CNT_W),
        .INIT_TIMEOUT(64), .MAX_STALL(16), .MIN_RETIRE(7)
    ) dut (
        .clock(clock), .resetn(resetn), .trig(trig), .check(check), .waive(waive),
        .rvfi_valid(rvfi_valid), .rvfi_halt(rvfi_halt), .rvfi_insn(rvfi_insn),
        .state(state), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt),
        .fail(fail), .fail_code(fail_code)
    );

    always #5 clock = ~clock;

    // Edge index since reset release: the first rising edge after release is edge 1.
    int cyc;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int    when;
        bit    imm;
        string name;
        int    st;
        int    stall;   // -1 = not compared
        int    ret;     // -1 = not compared
        int    f;
        int    code;
    } exp_t;

    exp_t sb[$];
    event async_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic check_it(input string name, input bit ok, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, required %s", name, act, req);
        end
    endtask

    function automatic string fmt(int st, int stl, int ret, int f, int code);
        return $sformatf("state=%0d stall=%0d retire=%0d fail=%0d code=%0d", st, stl, ret, f, code);
    endfunction

    task automatic compare(input exp_t e);
        bit ok;
        ok = (int'(state) == e.st) && (e.stall < 0 || int'(stall_cnt) == e.stall) &&
             (e.ret < 0 || int'(retire_cnt) == e.ret) && (int'(fail) == e.f) &&
             (int'(fail_code) == e.code);
        check_it(e.name, ok,
                 fmt(int'(state), int'(stall_cnt), int'(retire_cnt), int'(fail), int'(fail_code)),
                 fmt(e.st, e.stall, e.ret, e.f, e.code));
    endtask

    // Monitor: pops expectations whose edge has arrived.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock or async_ev);
            while (sb.size() > 0) begin
                e = sb[0];
                if (e.imm || e.when == cyc) begin
                    void'(sb.pop_front());
                    compare(e);
                end else if (e.when < cyc) begin
                    void'(sb.pop_front());
                    check_it(e.name, 1'b0, $sformatf("no sample at edge %0d", e.when), "sampled");
                end else begin
                    break;
                end
            end
        end
    end

    task automatic push(input string name, input bit imm, input int st, input int stl,
                        input int ret, input int f, input int code);
        exp_t e;
        e.when = cyc + 1; e.imm = imm; e.name = name;
        e.st = st; e.stall = stl; e.ret = ret; e.f = f; e.code = code;
        sb.push_back(e);
    endtask

    // Expected state after the upcoming rising edge.
    task automatic exp_next(input string name, input int st, input int stl, input int ret,
                            input int f, input int code);
        push(name, 1'b0, st, stl, ret, f, code);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        trig = 1'b0; check = 1'b0; waive = 1'b0;
        rvfi_valid = '0; rvfi_halt = '0; rvfi_insn = '0;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
        rvfi_valid = v;
        rvfi_insn  = {i1, i0};
    endtask

    // Asserts reset between edges and checks the outputs cleared without a clock edge.
    task automatic do_reset(input string name);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        idle();
        #1;
        push(name, 1'b1, 0, 0, 0, 0, 0);
        ->async_ev;
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;
    endtask

    task automatic run_init();
        for (int e = 1; e <= 70; e++) begin
            idle();
            if (e == 63) exp_next("init_edge63", 0, 63, 0, 0, 0);
            if (e == 64) exp_next("init_timeout", 3, -1, 0, 1, 1);
            if (e == 70) exp_next("init_sticky", 3, -1, 0, 1, 1);
            tick();
        end
    endtask

    task automatic run_stall(input bit use_waive, input bit with_check);
        int fe;
        fe = use_waive ? 24 : 21;
        for (int e = 1; e <= fe + 3; e++) begin
            idle();
            if (e == 5) drive(2'b01, NOP, 32'h0);
            if (use_waive && e >= 8 && e <= 10) waive = 1'b1;
            if (with_check && e == fe) check = 1'b1;
            if (e == 4)  exp_next("stall_wait", 0, 4, 0, 0, 0);
            if (e == 5)  exp_next("stall_first_retire", 1, 0, 1, 0, 0);
            if (use_waive && e == 10) exp_next("stall_waive_hold", 1, 2, 1, 0, 0);
            if (e == fe - 1) exp_next("stall_cnt_15", 1, 15, 1, 0, 0);
            if (e == fe) exp_next(with_check ? "stall_beats_check" : "stall_timeout", 3, -1, 1, 1, 2);
            if (e == fe + 3) exp_next("stall_sticky", 3, -1, 1, 1, 2);
            tick();
        end
    endtask

    // variant 0: check with one retirement passes; 1: idle check fails; 2: trig+check same cycle.
    task automatic run_window(input int variant);
        for (int e = 1; e <= 6; e++) begin
            idle();
            case (e)
                1: begin drive(2'b01, NOP, 32'h0); exp_next("win_first", 1, 0, 1, 0, 0); end
                2: begin trig = 1'b1; drive(2'b11, NOP, NOP); exp_next("win_trig", 1, 0, 2, 0, 0); end
                3: drive(2'b11, NOP, NOP);
                4: begin drive(2'b11, NOP, NOP); exp_next("win_cnt6", 1, 0, 6, 0, 0); end
                5: begin
                    check = 1'b1;
                    if (variant == 0) begin
                        drive(2'b01, NOP, 32'h0);
                        exp_next("win_check_pass", 1, 0, 7, 0, 0);
                    end else if (variant == 1) begin
                        exp_next("win_check_idle_fail", 3, -1, 6, 1, 3);
                    end else begin
                        trig = 1'b1;
                        drive(2'b11, NOP, NOP);
                        exp_next("win_trig_check_fail", 3, -1, 2, 1, 3);
                    end
                end
                default: begin
                    if (variant == 0) exp_next("win_after_pass", 1, 1, 7, 0, 0);
                    else              exp_next("win_fail_sticky", 3, -1, -1, 1, 3);
                end
            endcase
            tick();
        end
    endtask

    task automatic run_wfi();
        for (int e = 1; e <= 102; e++) begin
            idle();
            if (e == 1) drive(2'b01, NOP, 32'h0);
            if (e == 2) drive(2'b01, WFI, 32'h0);
`ifdef RVFI_PROGRESS_EXEMPT_EN
            if (e == 2)   exp_next("wfi_exempt", 2, 0, 1, 0, 0);
            if (e == 102) exp_next("wfi_exempt_idle", 2, 100, 1, 0, 0);
`else
            if (e == 2)   exp_next("wfi_counts", 1, 0, 2, 0, 0);
            if (e == 17)  exp_next("wfi_stall15", 1, 15, 2, 0, 0);
            if (e == 18)  exp_next("wfi_stall_fail", 3, -1, 2, 1, 2);
            if (e == 102) exp_next("wfi_sticky", 3, -1, 2, 1, 2);
`endif
            tick();
        end
    endtask

    task automatic run_saturate();
        for (int e = 1; e <= 130; e++) begin
            idle();
            drive(2'b11, NOP, NOP);
            if (e == 1)   exp_next("sat_first", 1, 0, 2, 0, 0);
            if (e == 127) exp_next("sat_254", 1, 0, 254, 0, 0);
            if (e == 128) exp_next("sat_255", 1, 0, 255, 0, 0);
            if (e == 130) exp_next("sat_hold", 1, 0, 255, 0, 0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        do_reset("reset_initial");
        run_init();
        do_reset("reset_async_after_init_fail");
        run_stall(1'b0, 1'b0);
        do_reset("reset_async_after_stall_fail");
        run_stall(1'b1, 1'b0);
        do_reset("reset_async_after_waive_fail");
        run_stall(1'b0, 1'b1);
        do_reset("reset_async_after_combo_fail");
        run_window(0);
        do_reset("reset_async_from_run");
        run_window(1);
        do_reset("reset_async_after_check_fail");
        run_window(2);
        do_reset("reset_async_after_trigcheck_fail");
        run_wfi();
        do_reset("reset_async_after_wfi");
        run_saturate();
        do_reset("reset_async_final");
        repeat (4) @(negedge clock);
        check_it("scoreboard_drain", sb.size() == 0,
                 $sformatf("%0d pending", sb.size()), "0 pending");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
